// File: rtl/m_btn_event.sv
// m_btn_event: classifies debounced button gestures into short press,
// double click, long press and auto-repeat strobes, timed in CE ticks.
// Ports:
//   CLK, RST_N (async, active-low), CE (time-base tick),
//   BTN_LVL (debounced level, 1 = pressed),
//   SHORT_P / DBL_P / LONG_P / RPT_P (one-cycle strobes),
//   HELD (level, high while in the hold state).
module m_btn_event #(
    parameter int CNT_WIDTH  = 12,
    parameter int LONG_TICKS = 1000,
    parameter int DBL_TICKS  = 250,
    parameter int RPT_TICKS  = 100
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CE,
    input  logic BTN_LVL,
    output logic SHORT_P,
    output logic DBL_P,
    output logic LONG_P,
    output logic RPT_P,
    output logic HELD
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_WAIT2,
        S_PRESS2,
        S_HOLD
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] DBL_LAST  = CNT_WIDTH'(DBL_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] RPT_LAST  = CNT_WIDTH'(RPT_TICKS - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 btn_q;
    logic                 arm_q;
    logic                 short_q, short_d;
    logic                 dbl_q, dbl_d;
    logic                 long_q, long_d;
    logic                 rpt_q, rpt_d;
    logic                 held_q, held_d;

    logic rise;
    logic fall;
    logic long_hit;
    logic dbl_hit;
    logic rpt_hit;

    assign rise     = BTN_LVL & ~btn_q;
    assign fall     = ~BTN_LVL & btn_q;
    assign long_hit = CE && (cnt_q == LONG_LAST);
    assign dbl_hit  = CE && (cnt_q == DBL_LAST);
    assign rpt_hit  = CE && (cnt_q == RPT_LAST);

    // Edges are tested before thresholds so a release or re-press on
    // the timeout cycle wins over the timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = CE ? cnt_q + 1'b1 : cnt_q;
        short_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
        rpt_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rise && arm_q) state_d = S_PRESS1;
            end
            S_PRESS1: begin
                if (fall) begin
                    state_d = S_WAIT2;
                end else if (long_hit) begin
                    long_d  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_WAIT2: begin
                if (rise) begin
                    state_d = S_PRESS2;
                end else if (dbl_hit) begin
                    short_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PRESS2: begin
                if (fall) begin
                    dbl_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (long_hit) begin
                    long_d  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (fall) begin
                    state_d = S_IDLE;
                end else if (rpt_hit) begin
                    rpt_d = 1'b1;
                    cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
        held_d = (state_d == S_HOLD);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            btn_q   <= 1'b0;
            arm_q   <= 1'b0;
            short_q <= 1'b0;
            dbl_q   <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            btn_q   <= BTN_LVL;
            // A button held through reset stays unarmed until released.
            arm_q   <= arm_q | ~BTN_LVL;
            short_q <= short_d;
            dbl_q   <= dbl_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
            held_q  <= held_d;
        end
    end

    assign SHORT_P = short_q;
    assign DBL_P   = dbl_q;
    assign LONG_P  = long_q;
    assign RPT_P   = rpt_q;
    assign HELD    = held_q;

endmodule

// File: tb/tb_m_btn_event.sv
// tb_m_btn_event: directed gesture sequences for m_btn_event with
// CE every cycle, LONG_TICKS=8, DBL_TICKS=4, RPT_TICKS=3.
module tb_m_btn_event;

    logic CLK;
    logic RST_N;
    logic CE;
    logic BTN_LVL;
    logic SHORT_P;
    logic DBL_P;
    logic LONG_P;
    logic RPT_P;
    logic HELD;

    int n_assert = 0;
    int n_fail   = 0;

    int tcyc = 0;
    int n_short, n_dbl, n_long, n_rpt, n_held, n_multi;
    int t_short, t_dbl, t_long, t_rpt_first, t_rpt_last;
    int t_r, t_f;

    m_btn_event #(
        .CNT_WIDTH (12),
        .LONG_TICKS(8),
        .DBL_TICKS (4),
        .RPT_TICKS (3)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .CE     (CE),
        .BTN_LVL(BTN_LVL),
        .SHORT_P(SHORT_P),
        .DBL_P  (DBL_P),
        .LONG_P (LONG_P),
        .RPT_P  (RPT_P),
        .HELD   (HELD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_short = 0; n_dbl = 0; n_long = 0; n_rpt = 0;
        n_held = 0;
        t_short = -1; t_dbl = -1; t_long = -1;
        t_rpt_first = -1; t_rpt_last = -1;
    endtask

    // Drive the level for one cycle, then sample just after the edge.
    task automatic cyc(input logic b);
        int s;
        BTN_LVL = b;
        @(posedge CLK);
        #1;
        tcyc++;
        s = int'(SHORT_P) + int'(DBL_P) + int'(LONG_P) + int'(RPT_P);
        if (s > 1) n_multi++;
        if (SHORT_P) begin n_short++; t_short = tcyc; end
        if (DBL_P)   begin n_dbl++;   t_dbl   = tcyc; end
        if (LONG_P)  begin n_long++;  t_long  = tcyc; end
        if (RPT_P) begin
            n_rpt++;
            if (n_rpt == 1) t_rpt_first = tcyc;
            t_rpt_last = tcyc;
        end
        if (HELD) n_held++;
    endtask

    initial begin
        n_multi = 0;
        clear_stats();
        RST_N   = 1'b0;
        CE      = 1'b1;
        BTN_LVL = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_outs", int'({SHORT_P, DBL_P, LONG_P, RPT_P, HELD}), 0);
        RST_N = 1'b1;

        // Short press
        clear_stats();
        repeat (2) cyc(1'b0);
        cyc(1'b1);
        repeat (2) cyc(1'b1);
        cyc(1'b0);
        t_f = tcyc;
        repeat (8) cyc(1'b0);
        chk("short_cnt", n_short, 1);
        chk("short_time", t_short, t_f + 4);
        chk("short_others", n_dbl + n_long + n_rpt, 0);

        // Double click
        clear_stats();
        repeat (3) cyc(1'b1);
        repeat (2) cyc(1'b0);
        repeat (2) cyc(1'b1);
        cyc(1'b0);
        t_f = tcyc;
        repeat (8) cyc(1'b0);
        chk("dbl_cnt", n_dbl, 1);
        chk("dbl_time", t_dbl, t_f);
        chk("dbl_no_short", n_short, 0);
        chk("dbl_others", n_long + n_rpt, 0);

        // Long press with auto-repeat
        clear_stats();
        cyc(1'b1);
        t_r = tcyc;
        repeat (19) cyc(1'b1);
        chk("long_held_hi", int'(HELD), 1);
        cyc(1'b0);
        chk("long_held_lo", int'(HELD), 0);
        repeat (8) cyc(1'b0);
        chk("long_cnt", n_long, 1);
        chk("long_time", t_long, t_r + 8);
        chk("rpt_cnt", n_rpt, 3);
        chk("rpt_first", t_rpt_first, t_r + 11);
        chk("rpt_last", t_rpt_last, t_r + 17);
        chk("held_cycles", n_held, 12);
        chk("long_others", n_short + n_dbl, 0);

        // Release on the long-threshold cycle
        clear_stats();
        cyc(1'b1);
        repeat (7) cyc(1'b1);
        cyc(1'b0);
        t_f = tcyc;
        repeat (8) cyc(1'b0);
        chk("tie_no_long", n_long, 0);
        chk("tie_short_cnt", n_short, 1);
        chk("tie_short_time", t_short, t_f + 4);

        // CE stuck low: edges still tracked, no timeouts
        clear_stats();
        CE = 1'b0;
        repeat (12) cyc(1'b1);
        repeat (8) cyc(1'b0);
        chk("ce0_no_timeout", n_long + n_short + n_rpt, 0);
        cyc(1'b1);
        cyc(1'b0);
        repeat (2) cyc(1'b0);
        chk("ce0_dbl", n_dbl, 1);
        CE = 1'b1;
        repeat (6) cyc(1'b0);
        chk("ce0_after", n_short + n_long + n_rpt, 0);

        // Held through reset
        clear_stats();
        BTN_LVL = 1'b1;
        RST_N   = 1'b0;
        repeat (3) cyc(1'b1);
        RST_N = 1'b1;
        repeat (10) cyc(1'b1);
        chk("hold_rst_none", n_short + n_dbl + n_long + n_rpt + n_held, 0);
        cyc(1'b0);
        repeat (3) cyc(1'b1);
        cyc(1'b0);
        t_f = tcyc;
        repeat (6) cyc(1'b0);
        chk("hold_rst_short", n_short, 1);
        chk("hold_rst_time", t_short, t_f + 4);

        // Reset while in HOLD clears HELD at once
        clear_stats();
        repeat (10) cyc(1'b1);
        chk("hold_before_rst", int'(HELD), 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("hold_rst_async", int'(HELD), 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (3) cyc(1'b0);

        // Reset during WAIT2 abandons the gesture
        clear_stats();
        repeat (3) cyc(1'b1);
        repeat (2) cyc(1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        chk("wait2_rst_outs", int'({SHORT_P, DBL_P, LONG_P, RPT_P, HELD}), 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (10) cyc(1'b0);
        chk("wait2_rst_none", n_short + n_dbl + n_long + n_rpt, 0);

        chk("one_hot_strobes", n_multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
